// File: rtl/serial2parallel.sv
// LSB-first serial-to-parallel deserializer with a one-entry valid/ready
// holding register. Define S2P_PARITY_EN to add an even-parity bit per frame.
module serial2parallel #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din,
    output logic [NBITS-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

`ifdef S2P_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    bitctr;
    logic [CW-1:0]    bitctr_nxt;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] shreg_nxt;
    logic             done;
    logic [NBITS-1:0] frame_data;
    logic             frame_perr;

    // Frame FSM, bit counter and shift register state
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bitctr <= '0;
            shreg  <= '0;
        end else begin
            state  <= state_nxt;
            bitctr <= bitctr_nxt;
            shreg  <= shreg_nxt;
        end
    end

    // Next-state logic; flags frame completion with the assembled word
    always_comb begin
        state_nxt  = state;
        bitctr_nxt = bitctr;
        shreg_nxt  = shreg;
        done       = 1'b0;
        frame_data = shreg;
        frame_perr = 1'b0;
        unique case (state)
            IDLE: begin
                bitctr_nxt = '0;
                if (start) begin
                    shreg_nxt    = '0;
                    shreg_nxt[0] = din;
                    bitctr_nxt   = CW'(1);
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                shreg_nxt[bitctr] = din;
                if (bitctr == LAST) begin
                    bitctr_nxt = '0;
`ifdef S2P_PARITY_EN
                    state_nxt  = PARITY;
`else
                    state_nxt  = IDLE;
                    done       = 1'b1;
                    frame_data = shreg_nxt;
`endif
                end else begin
                    bitctr_nxt = bitctr + CW'(1);
                end
            end
`ifdef S2P_PARITY_EN
            PARITY: begin
                state_nxt  = IDLE;
                done       = 1'b1;
                frame_data = shreg;
                frame_perr = ^{shreg, din};
            end
`endif
            default: begin
                state_nxt  = IDLE;
                bitctr_nxt = '0;
            end
        endcase
    end

    // Holding register: load on completion unless a stalled byte blocks it
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    data_out   <= frame_data;
                    parity_err <= frame_perr;
                    out_valid  <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
